// File: rtl/demand_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : demand_arbiter
// Brief    : Debounces four vehicle-detector inputs into pending calls,
//            ages each call, and nominates the longest-waiting approach to
//            the phase controller. HOLD keeps the nomination until that
//            approach is served.
//            Optional macro DEMAND_ARB_STARVE_OVERRIDE_EN lets a starved
//            approach preempt a held, non-starved one.
// Revision : 1.0  initial release
// ============================================================================
module demand_arbiter #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_WAIT        = 1000,
    parameter int WAIT_W          = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] detect_i,
    input  logic [3:0] light_state_i,
    input  logic       maintenance_i,
    output logic [1:0] priority_o,
    output logic       priority_valid_o,
    output logic [3:0] pending_o,
    output logic       starved_o
);

    localparam int                DEB_W      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DEB_W-1:0]  c_DEB_MAX  = DEB_W'(DEBOUNCE_CYCLES);
    localparam logic [DEB_W-1:0]  c_DEB_ARM  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [WAIT_W-1:0] c_WAIT_SAT = '1;
    localparam logic [WAIT_W-1:0] c_MAX_WAIT = WAIT_W'(MAX_WAIT);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_HOLD = 1'b1;

    logic [DEB_W-1:0]  deb_q  [4];
    logic [DEB_W-1:0]  deb_d  [4];
    logic [WAIT_W-1:0] wait_q [4];
    logic [WAIT_W-1:0] wait_d [4];
    logic [3:0]        pending_q, pending_d;
    logic [3:0]        call;
    logic [3:0]        starve_vec;
    logic [0:0]        state_q, state_d;
    logic [1:0]        prio_q, prio_d;
    logic              valid_q, valid_d;
    logic              starved_q;

    logic [1:0]        sel_idx;
    logic [WAIT_W-1:0] sel_wait;
    logic              sel_found;

    // Per-approach debounce, call registration, pending flag and wait aging.
    // A call fires only on the arming count, so a saturated counter cannot
    // re-fire until detect drops and clears it.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            call[i] = detect_i[i] && (deb_q[i] == c_DEB_ARM);

            if (!detect_i[i])
                deb_d[i] = '0;
            else if (deb_q[i] != c_DEB_MAX)
                deb_d[i] = deb_q[i] + 1'b1;
            else
                deb_d[i] = deb_q[i];

            // Service beats a simultaneous new call.
            pending_d[i] = light_state_i[i] ? 1'b0 : (pending_q[i] | call[i]);

            if (pending_q[i] && !light_state_i[i])
                wait_d[i] = (wait_q[i] == c_WAIT_SAT) ? wait_q[i] : wait_q[i] + 1'b1;
            else
                wait_d[i] = '0;

            starve_vec[i] = pending_q[i] && (wait_q[i] >= c_MAX_WAIT);
        end
    end

    // Pick the pending approach with the largest wait; strict compare keeps
    // ties on the lowest index.
    always_comb begin
        sel_idx   = 2'd0;
        sel_wait  = '0;
        sel_found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (pending_q[i] && (!sel_found || (wait_q[i] > sel_wait))) begin
                sel_found = 1'b1;
                sel_idx   = 2'(i);
                sel_wait  = wait_q[i];
            end
        end
    end

`ifdef DEMAND_ARB_STARVE_OVERRIDE_EN
    logic [3:0] held_mask;
    logic       others_starved;
    assign held_mask      = 4'b0001 << prio_q;
    assign others_starved = (|(starve_vec & ~held_mask)) && !starve_vec[prio_q];
`endif

    // IDLE/HOLD next-state: latch a selection, then hold it until served.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        valid_d = valid_q;
        case (state_q)
            c_IDLE: begin
                valid_d = 1'b0;
                if (|pending_q) begin
                    prio_d  = sel_idx;
                    valid_d = 1'b1;
                    state_d = c_HOLD;
                end
            end
            c_HOLD: begin
                if (!pending_q[prio_q]) begin
                    state_d = c_IDLE;
                    valid_d = 1'b0;
                end
`ifdef DEMAND_ARB_STARVE_OVERRIDE_EN
                else if (others_starved) begin
                    prio_d = sel_idx;
                end
`endif
            end
            default: begin
                state_d = c_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // Demand state registers; maintenance wipes demand but not rst-only state.
    always_ff @(posedge clk) begin
        if (rst || maintenance_i) begin
            pending_q <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                deb_q[i]  <= '0;
                wait_q[i] <= '0;
            end
        end else begin
            pending_q <= pending_d;
            for (int i = 0; i < 4; i++) begin
                deb_q[i]  <= deb_d[i];
                wait_q[i] <= wait_d[i];
            end
        end
    end

    // Arbiter FSM registers; priority survives maintenance, only rst zeroes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_IDLE;
            prio_q  <= 2'd0;
            valid_q <= 1'b0;
        end else if (maintenance_i) begin
            state_q <= c_IDLE;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            valid_q <= valid_d;
        end
    end

    // Starvation flag lags the wait counters by one cycle.
    always_ff @(posedge clk) begin
        if (rst)
            starved_q <= 1'b0;
        else
            starved_q <= |starve_vec;
    end

    assign priority_o       = prio_q;
    assign priority_valid_o = valid_q;
    assign pending_o        = pending_q;
    assign starved_o        = starved_q;

endmodule
`default_nettype wire
